// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer for the MIPS program counter: owns the PC, issues instruction
// memory requests, holds the fetched word for decode and applies redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc,
  input  logic [31:0] exc_pc,
  output logic [31:0] pc_out,
  output logic [31:0] epc,
  output logic [1:0]  exc_cause
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_EXT      = 2'b01,
    CAUSE_MISALIGN = 2'b10
  } cause_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] epc_q, epc_d;
  cause_e      cause_q, cause_d;

  // Resolved redirect for this cycle.
  logic        redir;
  logic [31:0] raw_target;
  logic [31:0] redir_target;
  logic        redir_is_exc;
  logic [31:0] redir_epc;
  cause_e      redir_cause;

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    redir        = exc | jmp | br_taken;
    raw_target   = jmp ? jmp_target : br_target;
    redir_target = raw_target;
    redir_is_exc = 1'b0;
    redir_epc    = exc_pc;
    redir_cause  = CAUSE_NONE;
    if (exc) begin
      redir_target = EXC_VECTOR;
      redir_is_exc = 1'b1;
      redir_epc    = exc_pc;
      redir_cause  = CAUSE_EXT;
    end else if (raw_target[1:0] != 2'b00) begin
      // A misaligned jump/branch target is turned into an exception.
      redir_target = EXC_VECTOR;
      redir_is_exc = 1'b1;
      redir_epc    = raw_target;
      redir_cause  = CAUSE_MISALIGN;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    epc_d      = epc_q;
    cause_d    = cause_q;

    if (redir && redir_is_exc) begin
      epc_d   = redir_epc;
      cause_d = redir_cause;
    end

    unique case (state_q)
      S_IDLE: begin
        if (redir) pc_d = redir_target;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (imem_ack) begin
          if (redir) begin
            // Returned word belongs to the abandoned path: drop it.
            pc_d = redir_target;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = S_ISSUE;
          end
        end else if (redir) begin
          // The request must stay up with its address until acked.
          pending_d = redir_target;
          state_d   = S_DRAIN;
        end
      end

      S_ISSUE: begin
        if (redir) begin
          pc_d    = redir_target;
          state_d = S_FETCH;
        end else if (id_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end

      S_DRAIN: begin
        if (imem_ack) begin
          pc_d    = redir ? redir_target : pending_q;
          state_d = S_FETCH;
        end else if (redir) begin
          pending_d = redir_target;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from the same edge, independent of statement order.
  // NOTE: the instruction/address holding registers are reset too, so decode
  // and debug see defined zeros rather than leftovers after a mid-run reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VECTOR;
      pending_q  <= 32'h0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      epc_q      <= 32'h0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
    end
  end

  // DRAIN keeps presenting the old PC, which is only updated once the stale ack lands.
  assign imem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign epc         = epc_q;
  assign exc_cause   = cause_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: expected fetches are queued when the ack
// is driven and compared when decode sees instr_valid.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        id_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        exc;
  logic [31:0] exc_pc;
  logic [31:0] pc_out;
  logic [31:0] epc;
  logic [1:0]  exc_cause;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  pc_fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .id_ready   (id_ready),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .exc        (exc),
    .exc_pc     (exc_pc),
    .pc_out     (pc_out),
    .epc        (epc),
    .exc_cause  (exc_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed instr_valid with empty scoreboard, expected no instruction", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_instr"}, instr, e.ins);
      check({tag, "_pc"}, instr_pc, e.pc);
    end
  endtask

  // Complete one fetch at exp_addr: ack after 'delay' idle request cycles,
  // hold in ISSUE for 'hold' cycles, then accept.
  task automatic do_fetch(input logic [31:0] exp_addr, input int delay, input int hold);
    logic [31:0] held;
    check("req", {31'b0, imem_req}, 32'd1);
    check("addr", imem_addr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("req_wait", {31'b0, imem_req}, 32'd1);
      check("addr_stable", imem_addr, exp_addr);
      check("valid_wait", {31'b0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = mem_word(imem_addr);
    sb.push_back('{pc: exp_addr, ins: mem_word(exp_addr)});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("valid", {31'b0, instr_valid}, 32'd1);
    held = mem_word(exp_addr);
    sb_pop_check("issue");
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", {31'b0, instr_valid}, 32'd1);
      check("hold_instr", instr, held);
      check("hold_pc", instr_pc, exp_addr);
      check("hold_noreq", {31'b0, imem_req}, 32'd0);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("valid_clr", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    br_taken = 1'b0; br_target = 32'h0; jmp = 1'b0; jmp_target = 32'h0;
    exc = 1'b0; exc_pc = 32'h0;
    tick(); tick();

    check("rst_pc", pc_out, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_cause", {30'b0, exc_cause}, 32'd0);

    reset = 1'b1;
    check("idle_req", {31'b0, imem_req}, 32'd0);
    tick();

    // Sequential fetches with one cycle ack delay.
    for (int k = 0; k < 4; k++) do_fetch(32'(k * 4), 1, 0);

    // Decode stall for three cycles.
    do_fetch(32'h10, 0, 3);
    check("after_stall", imem_addr, 32'h14);

    // Branch while fetch outstanding; ack arrives two cycles later.
    br_taken = 1'b1; br_target = 32'h100;
    tick();
    br_taken = 1'b0;
    check("drain_req", {31'b0, imem_req}, 32'd1);
    check("drain_addr", imem_addr, 32'h14);
    tick();
    check("drain_addr2", imem_addr, 32'h14);
    check("drain_novalid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0014;
    tick();
    imem_ack = 1'b0;
    check("br_novalid", {31'b0, instr_valid}, 32'd0);
    do_fetch(32'h100, 0, 0);

    // Simultaneous exc/jmp/br: exception wins.
    exc = 1'b1; exc_pc = 32'h40; jmp = 1'b1; jmp_target = 32'h200;
    br_taken = 1'b1; br_target = 32'h300;
    tick();
    exc = 1'b0; jmp = 1'b0; br_taken = 1'b0;
    check("exc_epc", epc, 32'h40);
    check("exc_cause", {30'b0, exc_cause}, 32'd1);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    do_fetch(32'h80, 0, 0);

    // Misaligned jump kills the held instruction despite id_ready.
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
    sb.push_back('{pc: 32'h84, ins: mem_word(32'h84)});
    tick();
    imem_ack = 1'b0;
    check("kill_valid_pre", {31'b0, instr_valid}, 32'd1);
    sb_pop_check("kill");
    jmp = 1'b1; jmp_target = 32'h102; id_ready = 1'b1;
    tick();
    jmp = 1'b0; id_ready = 1'b0;
    check("kill_valid", {31'b0, instr_valid}, 32'd0);
    check("mis_addr", imem_addr, 32'h80);
    check("mis_epc", epc, 32'h102);
    check("mis_cause", {30'b0, exc_cause}, 32'd2);

    // Branch coinciding with ack: data dropped, cause/epc kept.
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0080; br_taken = 1'b1; br_target = 32'h200;
    tick();
    imem_ack = 1'b0; br_taken = 1'b0;
    check("ackbr_novalid", {31'b0, instr_valid}, 32'd0);
    check("ackbr_addr", imem_addr, 32'h200);
    check("ackbr_cause", {30'b0, exc_cause}, 32'd2);
    check("ackbr_epc", epc, 32'h102);

    // Redirects during DRAIN: latest wins, including on the ack cycle.
    br_taken = 1'b1; br_target = 32'h300;
    tick();
    br_taken = 1'b0;
    check("dr1_addr", imem_addr, 32'h200);
    jmp = 1'b1; jmp_target = 32'h400;
    tick();
    jmp = 1'b0;
    check("dr2_addr", imem_addr, 32'h200);
    br_taken = 1'b1; br_target = 32'h500; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0200;
    tick();
    br_taken = 1'b0; imem_ack = 1'b0;
    check("dr3_novalid", {31'b0, instr_valid}, 32'd0);
    do_fetch(32'h500, 0, 0);

    // PC wrap at the top of the address space.
    jmp = 1'b1; jmp_target = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0504;
    tick();
    jmp = 1'b0; imem_ack = 1'b0;
    do_fetch(32'hFFFF_FFFC, 1, 0);
    check("wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset during DRAIN.
    br_taken = 1'b1; br_target = 32'h40;
    tick();
    br_taken = 1'b0;
    check("pre_rst_drain", {31'b0, imem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_pc", pc_out, 32'h0);
    check("arst_instr", instr, 32'h0);
    check("arst_instr_pc", instr_pc, 32'h0);
    check("arst_epc", epc, 32'h0);
    check("arst_cause", {30'b0, exc_cause}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
    tick();
    imem_ack = 1'b0;
    reset = 1'b1;
    check("rel_req", {31'b0, imem_req}, 32'd0);
    check("rel_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    do_fetch(32'h0, 0, 0);
    check("refetch_next", imem_addr, 32'h4);

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch sequencer for the 32-bit program counter register of the MIPS core.
- Owns the PC value and issues instruction-memory requests.
- Holds each fetched instruction until decode accepts it.
- Applies redirects (branch, jump, exception) with fixed priority and discards fetches made stale by a redirect.
- Sits between the PC register/instruction memory and the decode stage.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset
EXC_VECTOR, 32'h0000_0080, PC loaded on any exception redirect

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address; equals pc_out
imem_ack  in  1  one-cycle pulse: imem_rdata valid, request complete
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instr/instr_pc valid to decode
instr  out  32  held instruction word
instr_pc  out  32  address of held instruction
id_ready  in  1  decode accepts instr this cycle
br_taken  in  1  branch redirect pulse
br_target  in  32  branch target
jmp  in  1  jump redirect pulse
jmp_target  in  32  jump target
exc  in  1  external exception pulse
exc_pc  in  32  faulting instruction address
pc_out  out  32  current PC
epc  out  32  exception PC
exc_cause  out  2  00 none, 01 external, 10 misaligned target

Behaviour:
Reset and clocking
- One clock. Reset is asynchronous, active-low, on port reset.
- On reset assertion: state=IDLE, pc_out=RESET_VECTOR, imem_req=0, instr_valid=0, instr=0, instr_pc=0, epc=0, exc_cause=00, pending redirect cleared.
- Reset asserted mid-operation aborts everything immediately. Any later imem_ack is ignored until state=FETCH.

States: IDLE, FETCH, ISSUE, DRAIN.
- IDLE: one cycle after reset release, imem_req=0. Go to FETCH.
- FETCH: imem_req=1, imem_addr=pc_out.
  - imem_addr must stay stable while imem_req=1.
  - On imem_ack with no redirect: instr<=imem_rdata, instr_pc<=pc_out, go to ISSUE.
  - Fetch latency is 1 cycle minimum, request to registered instr_valid.
- ISSUE: instr_valid=1, imem_req=0.
  - On id_ready: pc_out<=pc_out+4 (mod 2^32; FFFF_FFFC wraps to 0000_0000), instr_valid<=0, go to FETCH.
  - Next request therefore starts the cycle after acceptance.
- DRAIN: imem_req=1 with the old address, waiting for the ack of the stale request.
  - On imem_ack: discard the data, pc_out<=pending target, go to FETCH.

Redirects
- Any redirect input high in a cycle is a redirect event.
- Priority within a cycle: exc > jmp > br_taken.
- Target selection:
  - exc: target=EXC_VECTOR, epc<=exc_pc, exc_cause<=01.
  - jmp/br: target=jmp_target/br_target.
  - If target[1:0]!=0, it becomes an exception: target=EXC_VECTOR, epc<=offending target, exc_cause<=10.
- Effect of a redirect, by state:
  - IDLE: pc_out<=target, then FETCH.
  - FETCH, no ack: pending<=target, go to DRAIN.
  - FETCH with ack same cycle: discard data, pc_out<=target, stay in FETCH, new address next cycle.
  - ISSUE: held instruction killed (instr_valid<=0 next cycle, even if id_ready=1 same cycle), pc_out<=target, go to FETCH.
  - DRAIN: pending target overwritten; latest redirect wins.
  - DRAIN with ack same cycle: use the new target.
- exc_cause/epc hold their value until the next exception; they are not cleared by jmp/br.

Invariants
- instr_valid never asserts for a discarded fetch.
- imem_req never drops before imem_ack except on reset.

Test Plan:
- Reset release, imem_ack 1 cycle after each req, id_ready=1: imem_addr sequence 0,4,8,C; instr_valid pulses carry matching instr_pc.
- In ISSUE with id_ready=0 for 3 cycles: instr/instr_pc held stable, no imem_req. Then id_ready=1: next imem_addr=instr_pc+4.
- In FETCH, br_taken=1, br_target=0x100, ack delayed 2 cycles: stale data never presented; next imem_addr=0x100.
- Same cycle exc=1 (exc_pc=0x40), jmp=1, br_taken=1: next imem_addr=0x80, epc=0x40, exc_cause=01.
- jmp_target=0x102: next imem_addr=0x80, epc=0x102, exc_cause=10.
- PC reaching 0xFFFF_FFFC, accepted: next imem_addr=0x0. Reset asserted during DRAIN: outputs at reset values immediately, then refetch from 0x0.
